mem_arb: RTL and testbench
==========================

# mem_arb

Single-port external memory arbiter placed between the core's fetch interface (`ins_mod` external instruction port) and its data-memory port. Serialises instruction fetches and data loads/stores onto one external memory bus, one outstanding transaction at a time. Generates the pipeline `stall` that the core currently ties to 0. Data requests have priority, with a starvation limit that guarantees forward progress of fetch.

## Interface
- `STARVE_MAX`, 4: consecutive data grants allowed while a fetch waits; range 1..15.
- `TIMEOUT`, 255: cycles allowed in REQ+WAIT before abort; used only with `MEM_ARB_TIMEOUT_EN`; range 1..255.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_ren` in 1: fetch request; held with `if_addr` until `if_valid`.
- `if_addr` in 32: fetch byte address.
- `if_valid` out 1: one-cycle fetch completion pulse.
- `if_data` out 32: fetched word; meaningful only while `if_valid` is high.
- `dm_req` in 1: data request; held with all `dm_*` inputs until `dm_valid`.
- `dm_wen` in 1: 1 = store, 0 = load.
- `dm_addr` in 32, `dm_wdata` in 32, `dm_be` in 4: data address, store data, byte enables.
- `dm_valid` out 1: one-cycle data completion pulse; the pulse occurs for stores too.
- `dm_rdata` out 32: load data; meaningful only while `dm_valid` is high.
- `mem_req`, `mem_wen` out 1; `mem_addr`, `mem_wdata` out 32; `mem_be` out 4: external request. Fetches drive `mem_wen`=0 and `mem_be`=4'hF.
- `mem_gnt` in 1: memory accepts the request this cycle.
- `mem_done` in 1, `mem_rdata` in 32: transaction completion and read data. `mem_done` arrives at least 1 cycle after `mem_gnt`.
- `stall` out 1: freeze the core pipeline.
- `err` out 1: sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If `dm_req` or `if_ren` is high, latch the owner (D or I) and its address, data, `be` and `wen` into registers, then go to REQ.
  - Selection: D wins, except that when both requests are high and `starve_cnt == STARVE_MAX`, I wins.
- REQ: `mem_req`=1 and the bus is driven from the latched registers, stable until `mem_gnt`. On `mem_gnt`, go to WAIT.
- WAIT: `mem_req`=0. On `mem_done`, capture `mem_rdata` into the response register and go to RESP.
- RESP: pulse the owner's valid for one cycle with the captured data, then go to IDLE.
- `starve_cnt` (4 bits):
  - +1 on each D grant made while `if_ren` is high.
  - Cleared on an I grant, and cleared in any IDLE cycle where `if_ren` is low.
  - Saturates at `STARVE_MAX`.
- `stall` = (`dm_req` & !`dm_valid`) | (`if_ren` & !`if_valid`). This is combinational from the inputs and registered valids.
- Requester inputs are sampled only in IDLE. A request that is dropped early is still completed and pulsed.
- `mem_gnt` and `mem_done` are ignored outside REQ and WAIT respectively.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_wen`=0, `mem_addr`/`mem_wdata`=0, `mem_be`=0, `if_valid`=`dm_valid`=0, `if_data`=`dm_rdata`=0, `starve_cnt`=0, `err`=0.
- Reset mid-transaction abandons it with no valid pulse. The memory must be reset in the same cycle.
- Minimum latency: request seen in IDLE at cycle t → `mem_req` at t+1. With `mem_gnt` at t+1 and `mem_done` at t+2, valid is high at t+3.
- Back-to-back throughput: IDLE at t+4, so one transaction per 4 cycles minimum.
- `mem_gnt` in the same cycle `mem_req` first rises is legal, with a 1-cycle REQ.
- A simultaneous `mem_gnt` and `mem_done` in REQ is a protocol violation. `mem_done` is ignored in that case.
- The valid pulse never coincides with `mem_req`.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to REQ and increments in REQ and WAIT.
  - When it reaches `TIMEOUT`, go to RESP with response data 32'h0 and set `err`=1 until `rst`.
  - A late `mem_done` after the abort is ignored.
- `MEM_ARB_TIMEOUT_EN` undefined: REQ and WAIT wait indefinitely, no counter is built, and `err` is tied to 0.

## Test plan
- Fetch only: `if_addr`=0x100, memory grants immediately with `mem_done` 1 cycle later and `mem_rdata`=0x00500093. Expect `if_valid` 3 cycles after the request with `if_data`=0x00500093, and `stall` high for exactly those 3 cycles.
- Store: `dm_wen`=1, `dm_addr`=0x804, `dm_wdata`=0xDEADBEEF, `dm_be`=4'b0011. Expect `mem_wen`=1 with the bus matching the inputs, and a `dm_valid` pulse.
- Contention: `if_ren` and `dm_req` held high continuously with `STARVE_MAX`=4. Expect grant order D,D,D,D,I,D,D,D,D,I.
- Slow memory: `mem_gnt` delayed 5 cycles, `mem_done` delayed 7 more. Expect the bus held stable throughout REQ and a single valid pulse.
- Reset asserted in WAIT. Expect IDLE next cycle, no valid pulse, and a later `mem_done` ignored.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT`=16, memory never sends `mem_done`. Expect the valid pulse with data 0 on the 17th cycle after REQ entry, and `err`=1 until reset.

Source files
------------

// File: rtl/mem_arb_if.sv
// External memory bus of mem_arb: one request at a time, accepted by
// mem_gnt and completed by mem_done.
interface mem_arb_if;
   logic        mem_req;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_done;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_wen, mem_addr, mem_wdata, mem_be,
      input  mem_gnt, mem_done, mem_rdata
   );

   modport slave (
      input  mem_req, mem_wen, mem_addr, mem_wdata, mem_be,
      output mem_gnt, mem_done, mem_rdata
   );
endinterface

// File: rtl/mem_arb.sv
// Fetch/data arbiter onto a single external memory port, data-first with a
// fetch starvation limit. Optional transaction timeout: MEM_ARB_TIMEOUT_EN.
module mem_arb #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ren,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_data,
   input  logic        dm_req,
   input  logic        dm_wen,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_be,
   output logic        dm_valid,
   output logic [31:0] dm_rdata,
   mem_arb_if.master   mem,
   output logic        stall,
   output logic        err
);

   localparam logic [3:0] STARVE_CAP = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        own_dm_q, own_dm_d;
   logic        mem_req_q, mem_req_d;
   logic        wen_q, wen_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  be_q, be_d;
   logic [3:0]  starve_q, starve_d;
   logic        if_valid_q, if_valid_d;
   logic        dm_valid_q, dm_valid_d;
   logic        pick_if;
   logic        timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
   logic [7:0] tcnt_q, tcnt_d;
   logic       err_q, err_d;

   // Transaction age: zero outside REQ/WAIT so it starts at 0 on REQ entry
   always_comb begin
      tcnt_d      = tcnt_q;
      err_d       = err_q;
      timeout_hit = 1'b0;
      if (state_q == REQ || state_q == WAIT) begin
         timeout_hit = (tcnt_q == 8'(TIMEOUT));
         tcnt_d      = tcnt_q + 8'd1;
      end else begin
         tcnt_d = 8'd0;
      end
      if (timeout_hit) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Timeout counter and sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_q <= 8'd0;
         err_q  <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         err_q  <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign err            = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   // Next-state, request latching, response capture and starvation tracking
   always_comb begin
      state_d    = state_q;
      own_dm_d   = own_dm_q;
      mem_req_d  = mem_req_q;
      wen_d      = wen_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      rdata_d    = rdata_q;
      starve_d   = starve_q;
      if_valid_d = 1'b0;
      dm_valid_d = 1'b0;
      pick_if    = if_ren && (!dm_req || (starve_q == STARVE_CAP));
      case (state_q)
         IDLE: begin
            if (dm_req || if_ren) begin
               state_d   = REQ;
               mem_req_d = 1'b1;
               own_dm_d  = !pick_if;
               if (pick_if) begin
                  addr_d   = if_addr;
                  wdata_d  = 32'h0;
                  be_d     = 4'hF;
                  wen_d    = 1'b0;
                  starve_d = 4'd0;
               end else begin
                  addr_d  = dm_addr;
                  wdata_d = dm_wdata;
                  be_d    = dm_be;
                  wen_d   = dm_wen;
                  if (!if_ren) begin
                     starve_d = 4'd0;
                  end else if (starve_q == STARVE_CAP) begin
                     starve_d = starve_q;
                  end else begin
                     starve_d = starve_q + 4'd1;
                  end
               end
            end else begin
               state_d  = IDLE;
               starve_d = 4'd0;
            end
         end
         REQ: begin
            if (timeout_hit) begin
               state_d    = RESP;
               mem_req_d  = 1'b0;
               rdata_d    = 32'h0;
               if_valid_d = !own_dm_q;
               dm_valid_d = own_dm_q;
            end else if (mem.mem_gnt) begin
               state_d   = WAIT;
               mem_req_d = 1'b0;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (timeout_hit) begin
               state_d    = RESP;
               rdata_d    = 32'h0;
               if_valid_d = !own_dm_q;
               dm_valid_d = own_dm_q;
            end else if (mem.mem_done) begin
               state_d    = RESP;
               rdata_d    = mem.mem_rdata;
               if_valid_d = !own_dm_q;
               dm_valid_d = own_dm_q;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         own_dm_q   <= 1'b0;
         mem_req_q  <= 1'b0;
         wen_q      <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         be_q       <= 4'h0;
         rdata_q    <= 32'h0;
         starve_q   <= 4'd0;
         if_valid_q <= 1'b0;
         dm_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         own_dm_q   <= own_dm_d;
         mem_req_q  <= mem_req_d;
         wen_q      <= wen_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         rdata_q    <= rdata_d;
         starve_q   <= starve_d;
         if_valid_q <= if_valid_d;
         dm_valid_q <= dm_valid_d;
      end
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_wen   = wen_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_be    = be_q;
   assign if_valid      = if_valid_q;
   assign dm_valid      = dm_valid_q;
   assign if_data       = rdata_q;
   assign dm_rdata      = rdata_q;
   // Stall releases in the same cycle the completion pulse is seen
   assign stall = (dm_req & ~dm_valid_q) | (if_ren & ~if_valid_q);

endmodule

// File: tb/tb_mem_arb.sv
// Randomized self-checking bench for mem_arb against a transaction-level model
// of the arbiter, a behavioural memory and two requesters.
module tb_mem_arb;
   localparam int SM = 4;
   localparam int TO = 16;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_ren, dm_req, dm_wen;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic        if_valid, dm_valid, stall, err;
   logic [31:0] if_data, dm_rdata;

   mem_arb_if mbus ();

   mem_arb #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_ren(if_ren), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
      .dm_req(dm_req), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
      .mem(mbus), .stall(stall), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: bus phase of the current transaction and its owner
   typedef enum int {P_FREE, P_REQ, P_WAIT, P_RESP} ph_t;
   ph_t         ph;
   bit          own_d, s_wen, err_m;
   logic [31:0] s_addr, s_wdata, rdata_m, fix_rdata;
   logic [3:0]  s_be;
   int          starve_m, gnt_wait, done_wait, age, gnt_cfg, done_cfg;
   bit          fix_rdata_en, late_done, spurious_en, drop_en;
   bit          if_act, dm_act, if_auto, dm_auto, if_hold, dm_hold, if_go, dm_go, if_blk, dm_blk;
   logic [31:0] go_if_addr, go_dm_addr, go_dm_wdata;
   logic [3:0]  go_dm_be;
   bit          go_dm_wen, seen_if_v, seen_dm_v, st_obs;

   task automatic start_if(input logic [31:0] a);
      if_ren = 1'b1; if_addr = a; if_act = 1'b1;
   endtask

   task automatic start_dm(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      dm_req = 1'b1; dm_wen = w; dm_addr = a; dm_wdata = d; dm_be = be; dm_act = 1'b1;
   endtask

   task automatic rand_dm();
      start_dm(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom(), 4'($urandom_range(0, 15)));
   endtask

   // One clock cycle: check outputs, move requesters, answer as memory, advance model
   task automatic step();
      logic [1:0] exp_v;
      logic       exp_st;
      @(negedge clk);
      exp_v = (ph == P_RESP) ? (own_d ? 2'b10 : 2'b01) : 2'b00;
      check_eq("mem_req", 32'(mbus.mem_req), 32'(ph == P_REQ));
      check_eq("valid", 32'({dm_valid, if_valid}), 32'(exp_v));
      check_eq("err", 32'(err), 32'(err_m));
      seen_if_v = if_valid;
      seen_dm_v = dm_valid;
      if (ph == P_REQ) begin
         check_eq("bus_addr", mbus.mem_addr, s_addr);
         check_eq("bus_wen", 32'(mbus.mem_wen), 32'(s_wen));
         check_eq("bus_be", 32'(mbus.mem_be), 32'(s_be));
         if (own_d && s_wen) check_eq("bus_wdata", mbus.mem_wdata, s_wdata);
      end
      if (ph == P_RESP) begin
         if (own_d) check_eq("dm_rdata", dm_rdata, rdata_m);
         else       check_eq("if_data", if_data, rdata_m);
      end

      if (ph == P_RESP && own_d) begin
         dm_blk = 1'b0;
         if (dm_act) begin dm_act = 1'b0; dm_req = 1'b0; end
         if (dm_hold) rand_dm();
      end
      if (ph == P_RESP && !own_d) begin
         if_blk = 1'b0;
         if (if_act) begin if_act = 1'b0; if_ren = 1'b0; end
         if (if_hold) start_if($urandom() & 32'hFFFF_FFFC);
      end
      if (if_go && !if_act) begin start_if(go_if_addr); if_go = 1'b0; end
      if (dm_go && !dm_act) begin start_dm(go_dm_wen, go_dm_addr, go_dm_wdata, go_dm_be); dm_go = 1'b0; end
      if (if_auto && !if_act && !if_blk && $urandom_range(0, 3) == 0) start_if($urandom() & 32'hFFFF_FFFC);
      if (dm_auto && !dm_act && !dm_blk && $urandom_range(0, 3) == 0) rand_dm();
      if (drop_en && ph == P_WAIT && $urandom_range(0, 15) == 0) begin
         if (own_d && dm_act) begin dm_act = 1'b0; dm_req = 1'b0; dm_blk = 1'b1; end
         if (!own_d && if_act) begin if_act = 1'b0; if_ren = 1'b0; if_blk = 1'b1; end
      end

      mbus.mem_gnt   = 1'b0;
      mbus.mem_done  = 1'b0;
      mbus.mem_rdata = $urandom();
      case (ph)
         P_FREE: begin
            if (late_done) begin mbus.mem_done = 1'b1; late_done = 1'b0; end
            if (spurious_en && $urandom_range(0, 7) == 0) mbus.mem_gnt = 1'b1;
            if (spurious_en && $urandom_range(0, 7) == 0) mbus.mem_done = 1'b1;
            if (!if_ren) starve_m = 0;
            if (if_ren || dm_req) begin
               own_d = dm_req && !(if_ren && starve_m == SM);
               if (own_d) begin
                  s_addr = dm_addr; s_wdata = dm_wdata; s_be = dm_be; s_wen = dm_wen;
                  if (if_ren) starve_m = (starve_m < SM) ? starve_m + 1 : SM;
               end else begin
                  s_addr = if_addr; s_be = 4'hF; s_wen = 1'b0; starve_m = 0;
               end
               gnt_wait = (gnt_cfg < 0) ? int'($urandom_range(0, 3)) : gnt_cfg;
               age = 0;
               ph  = P_REQ;
            end
         end
         P_REQ: begin
            if (TO_EN && age == TO) begin
               ph = P_RESP; rdata_m = 32'h0; err_m = 1'b1;
            end else if (gnt_wait == 0) begin
               mbus.mem_gnt = 1'b1;
               if (spurious_en) mbus.mem_done = 1'($urandom_range(0, 1));
               done_wait = (done_cfg < 0) ? int'($urandom_range(0, 3)) : done_cfg;
               ph = P_WAIT;
            end else begin
               gnt_wait--;
            end
            age++;
         end
         P_WAIT: begin
            if (TO_EN && age == TO) begin
               ph = P_RESP; rdata_m = 32'h0; err_m = 1'b1;
            end else if (done_wait == 0) begin
               mbus.mem_done  = 1'b1;
               mbus.mem_rdata = fix_rdata_en ? fix_rdata : $urandom();
               rdata_m = mbus.mem_rdata;
               ph = P_RESP;
            end else begin
               done_wait--;
            end
            age++;
         end
         P_RESP: begin
            if (spurious_en) mbus.mem_gnt = 1'($urandom_range(0, 1));
            if (spurious_en) mbus.mem_done = 1'($urandom_range(0, 1));
            ph = P_FREE;
         end
         default: ph = P_FREE;
      endcase
      #1;
      exp_st = (dm_req & ~exp_v[1]) | (if_ren & ~exp_v[0]);
      st_obs = stall;
      check_eq("stall", 32'(stall), 32'(exp_st));
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      if_ren = 1'b0; dm_req = 1'b0; if_act = 1'b0; dm_act = 1'b0; if_blk = 1'b0; dm_blk = 1'b0;
      mbus.mem_gnt = 1'b0; mbus.mem_done = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      ph = P_FREE; starve_m = 0; err_m = 1'b0;
      check_eq("rst_mem_req", 32'(mbus.mem_req), 32'd0);
      check_eq("rst_mem_wen", 32'(mbus.mem_wen), 32'd0);
      check_eq("rst_mem_addr", mbus.mem_addr, 32'h0);
      check_eq("rst_mem_wdata", mbus.mem_wdata, 32'h0);
      check_eq("rst_mem_be", 32'(mbus.mem_be), 32'd0);
      check_eq("rst_valids", 32'({dm_valid, if_valid}), 32'd0);
      check_eq("rst_if_data", if_data, 32'h0);
      check_eq("rst_dm_rdata", dm_rdata, 32'h0);
      check_eq("rst_err", 32'(err), 32'd0);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((if_act || dm_act || ph != P_FREE) && n < 200) begin
         step();
         n++;
      end
      check_eq(tag, 32'(ph == P_FREE && !if_act && !dm_act), 32'd1);
   endtask

   initial begin
      int n, cnt, stall_cnt;
      bit [9:0] gv;
      rst = 1'b1;
      if_ren = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_wen = 1'b0;
      dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
      mbus.mem_gnt = 1'b0; mbus.mem_done = 1'b0; mbus.mem_rdata = 32'h0;
      gnt_cfg = -1; done_cfg = -1; err_m = 1'b0; ph = P_FREE; starve_m = 0;
      do_reset(3);

      // Fetch only, fastest memory
      gnt_cfg = 0; done_cfg = 0; fix_rdata_en = 1'b1; fix_rdata = 32'h0050_0093;
      go_if_addr = 32'h100; if_go = 1'b1;
      stall_cnt = 0; n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (st_obs) stall_cnt++;
         n = i;
         if (seen_if_v) break;
      end
      check_eq("fetch_latency", 32'(n), 32'd3);
      check_eq("fetch_stall_cycles", 32'(stall_cnt), 32'd3);
      fix_rdata_en = 1'b0;
      drain("fetch_drain");

      // Store
      go_dm_wen = 1'b1; go_dm_addr = 32'h804; go_dm_wdata = 32'hDEAD_BEEF; go_dm_be = 4'b0011;
      dm_go = 1'b1; cnt = 0;
      for (int i = 0; i < 20 && cnt == 0; i++) begin
         step();
         if (seen_dm_v) cnt++;
      end
      check_eq("store_done", 32'(cnt), 32'd1);
      drain("store_drain");

      // Contention with both requests held high
      gnt_cfg = -1; done_cfg = -1;
      if_hold = 1'b1; dm_hold = 1'b1;
      go_if_addr = 32'h200; if_go = 1'b1;
      go_dm_wen = 1'b0; go_dm_addr = 32'h900; go_dm_wdata = 32'h0; go_dm_be = 4'hF; dm_go = 1'b1;
      cnt = 0; gv = 10'b0;
      for (int i = 0; i < 400 && cnt < 10; i++) begin
         step();
         if (seen_dm_v || seen_if_v) begin
            gv[9 - cnt] = seen_dm_v;
            cnt++;
         end
      end
      check_eq("grant_order", 32'(gv), 32'(10'b1111011110));
      if_hold = 1'b0; dm_hold = 1'b0;
      drain("contention_drain");

      // Slow memory: grant after 5 cycles, done 7 cycles after grant
      gnt_cfg = 5; done_cfg = 6;
      go_dm_wen = 1'b0; go_dm_addr = 32'h0000_1F00; go_dm_wdata = 32'h0; go_dm_be = 4'hF; dm_go = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         n = i;
         if (seen_dm_v) break;
      end
      check_eq("slow_latency", 32'(n), 32'd14);
      drain("slow_drain");

      // Reset while waiting for mem_done, then a stale mem_done
      gnt_cfg = 0; done_cfg = 5;
      go_if_addr = 32'h300; if_go = 1'b1;
      for (int i = 0; i < 10 && ph != P_WAIT; i++) step();
      check_eq("reached_wait", 32'(ph == P_WAIT), 32'd1);
      do_reset(1);
      late_done = 1'b1; cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (seen_if_v || seen_dm_v) cnt++;
      end
      check_eq("rst_no_valid", 32'(cnt), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
      // Memory never completes: abort after TIMEOUT cycles
      gnt_cfg = 0; done_cfg = 1000;
      go_if_addr = 32'h400; if_go = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         n = i;
         if (seen_if_v) break;
      end
      check_eq("timeout_latency", 32'(n), 32'(TO + 2));
      for (int i = 0; i < 5; i++) step();
      check_eq("timeout_err_sticky", 32'(err), 32'd1);
      do_reset(1);
`endif

      // Randomized traffic
      gnt_cfg = -1; done_cfg = -1;
      if_auto = 1'b1; dm_auto = 1'b1; spurious_en = 1'b1; drop_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            if_hold = ~if_hold;
            dm_hold = 1'($urandom_range(0, 1));
         end
         step();
      end
      if_auto = 1'b0; dm_auto = 1'b0; if_hold = 1'b0; dm_hold = 1'b0;
      spurious_en = 1'b0; drop_en = 1'b0;
      drain("random_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
